// File: rtl/core_ctrl_mc.sv
// Multicycle core controller: fetch, optional second instruction word, optional
// data access, then one execute/writeback cycle. It is the only master on the memory port.
module core_ctrl_mc #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 15,
    parameter int BANK_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic [BANK_W+DATA_W-1:0] mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     halted
);

    localparam logic [PC_W-1:0]   PC_RST = PC_W'(RESET_PC);
    localparam logic [DATA_W-1:0] DW_L   = DATA_W'(DATA_W);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_SEQ   = 4'h5;
    localparam logic [3:0] OP_SLT   = 4'h6;
    localparam logic [3:0] OP_BEQ   = 4'h7;
    localparam logic [3:0] OP_J     = 4'h8;
    localparam logic [3:0] OP_JAL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_SHL   = 4'hB;
    localparam logic [3:0] OP_NAND  = 4'hC;
    localparam logic [3:0] OP_LOADI = 4'hD;
    localparam logic [3:0] OP_WR    = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_FETCH2,
        ST_MEM,
        ST_EXEC,
        ST_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] w2_q, w2_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];

    logic [3:0]        op, fa, fb, fc;
    logic [DATA_W-1:0] rf_a, rf_b, rf_c;
    logic [DATA_W-1:0] imm4, imm8, shamt, alu_res;
    logic [PC_W-1:0]   pc_inc1, pc_inc2, jmp_tgt, pc_exec;
    logic [BANK_W-1:0] bank;
    logic              wb_en;
    logic [3:0]        wb_idx;
    logic [DATA_W-1:0] wb_val;

    assign op      = ir_q[15:12];
    assign fa      = ir_q[11:8];
    assign fb      = ir_q[7:4];
    assign fc      = ir_q[3:0];
    assign rf_a    = rf_q[fa];
    assign rf_b    = rf_q[fb];
    assign rf_c    = rf_q[fc];
    assign imm4    = DATA_W'(signed'(ir_q[3:0]));
    assign imm8    = DATA_W'(signed'(ir_q[7:0]));
    assign shamt   = rf_c % DW_L;
    assign pc_inc1 = pc_q + PC_W'(1);
    assign pc_inc2 = pc_inc1 + PC_W'(1);
    assign jmp_tgt = PC_W'(ir_q[11:0]);
    assign bank    = BANK_W'(ir_q[7:0]);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rf_b + rf_c;
            OP_ADDI: alu_res = rf_b + imm4;
            OP_SUB:  alu_res = rf_b - rf_c;
            OP_SEQ:  alu_res = DATA_W'(rf_b == rf_c);
            OP_SLT:  alu_res = DATA_W'($signed(rf_b) < $signed(rf_c));
            OP_SHR:  alu_res = rf_b >> shamt;
            OP_SHL:  alu_res = rf_b << shamt;
            OP_NAND: alu_res = ~(rf_b & rf_c);
            default: alu_res = '0;
        endcase
    end

    // Writeback selection and next PC for the EXEC cycle.
    always_comb begin
        wb_en   = 1'b0;
        wb_idx  = fa;
        wb_val  = alu_res;
        pc_exec = pc_inc1;
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_SEQ, OP_SLT, OP_SHR, OP_SHL, OP_NAND: wb_en = 1'b1;
            OP_LOAD: begin
                wb_en   = 1'b1;
                wb_val  = mdr_q;
                pc_exec = pc_inc2;
            end
            OP_STORE: pc_exec = pc_inc2;
            OP_BEQ:   pc_exec = (rf_a == rf_b) ? w2_q[PC_W-1:0] : pc_inc2;
            OP_J:     pc_exec = jmp_tgt;
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_idx  = 4'd15;
                wb_val  = DATA_W'(pc_inc1);
                pc_exec = jmp_tgt;
            end
            OP_LOADI: begin
                wb_en  = 1'b1;
                wb_val = imm8;
            end
            default: ;
        endcase
    end

    // Handshake: mem_req acts as valid and mem_ready as ready; an access completes
    // on a rising edge with both high, and addr/we/wdata are held until then.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        halted    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {{BANK_W{1'b0}}, DATA_W'(pc_q)};
            end
            ST_FETCH2: begin
                mem_req  = 1'b1;
                mem_addr = {{BANK_W{1'b0}}, DATA_W'(pc_inc1)};
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (op == OP_WR) begin
                    mem_addr  = {{BANK_W{1'b0}}, rf_b};
                    mem_we    = 1'b1;
                    mem_wdata = rf_a;
                end else begin
                    mem_addr = {bank, w2_q};
                    if (op == OP_STORE) begin
                        mem_we    = 1'b1;
                        mem_wdata = rf_a;
                    end
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        w2_d    = w2_q;
        mdr_d   = mdr_q;
        rf_d    = rf_q;
        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d = mem_rdata[15:0];
                    case (mem_rdata[15:12])
                        OP_LOAD, OP_STORE, OP_BEQ: state_d = ST_FETCH2;
                        OP_WR:                     state_d = ST_MEM;
                        OP_HALT:                   state_d = ST_HALT;
                        default:                   state_d = ST_EXEC;
                    endcase
                end
            end
            ST_FETCH2: begin
                if (mem_ready) begin
                    w2_d    = mem_rdata;
                    state_d = (op == OP_BEQ) ? ST_EXEC : ST_MEM;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (op == OP_LOAD) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (wb_en && (wb_idx != 4'd0)) begin
                    rf_d[wb_idx] = wb_val;
                end
                pc_d    = pc_exec;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            pc_q    <= PC_RST;
            ir_q    <= '0;
            w2_q    <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            w2_q    <= w2_d;
            mdr_q   <= mdr_d;
            rf_q    <= rf_d;
        end
    end

endmodule

// File: doc/core_ctrl_mc.md
# core_ctrl_mc

Parametrised multicycle core controller: the next generation of the 16-bit three-stage core. Fetches 16-bit instructions from a banked word-addressed memory, executes a 16-opcode ISA against an internal 16-entry register file, and tolerates variable memory latency via a req/ready handshake. Adds data-width generalisation, wait-state support, `jal`, `halt` and a clean reset; it is the sole bus master on the memory port.

## Interface
- `DATA_W`, 16: register and datapath width, ≥16. Instructions always occupy the `mem_rdata[15:0]` bits.
- `PC_W`, 15: program counter width, ≤ `DATA_W`.
- `BANK_W`, 8: bank field width. Memory address width is `BANK_W+DATA_W`.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_rdata`  in  `DATA_W`  read data; valid in a cycle where `mem_ready`=1.
- `mem_ready`  in  1  completes the current access.
- `mem_req`  out  1  access request.
- `mem_addr`  out  `BANK_W+DATA_W`  word address.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `mem_wdata`  out  `DATA_W`  write data; 0 when `mem_we`=0.
- `halted`  out  1  high while in HALT.

## Operation
- Fields: op=`ir[15:12]`, a=`ir[11:8]`, b=`ir[7:4]`, c=`ir[3:0]`. R[0] reads 0 and ignores writes. All arithmetic is modulo 2^`DATA_W`.
- Opcodes:
  - 0 add: R[a]=R[b]+R[c]
  - 1 addi: R[a]=R[b]+sext(c)
  - 2 sub: R[a]=R[b]−R[c]
  - 3 load: R[a]=M[{ir[7:0],w2}]
  - 4 store: M[{ir[7:0],w2}]=R[a]
  - 5 seq: R[a]=(R[b]==R[c])
  - 6 slt: R[a]=signed(R[b]<R[c])
  - 7 beq: if R[a]==R[b], PC=w2[PC_W-1:0]
  - 8 j: PC=zext(ir[11:0])
  - 9 jal: R[15]=PC+1, then PC=zext(ir[11:0])
  - A shr: R[a]=R[b]>>R[c] (logical)
  - B shl: R[a]=R[b]<<R[c]
  - C nand: R[a]=~(R[b]&R[c])
  - D loadi: R[a]=sext(ir[7:0])
  - E wr: M[zext(R[b])]=R[a]
  - F halt
- Encoding details:
  - Bank field `ir[7:0]` is zero-extended or truncated to `BANK_W`.
  - w2 is the second instruction word at PC+1, used by ops 3, 4 and 7.
  - Shift amount is R[c] mod `DATA_W`. A shift amount ≥ `DATA_W` cannot occur.
- Without a taken jump, PC advances by 1 for one-word instructions and by 2 for two-word instructions, wrapping modulo 2^`PC_W`.
- State machine:
  - START → FETCH.
  - FETCH: read {0,PC}. On ready, latch ir. Ops 3/4/7 go to FETCH2, E goes to MEM, F goes to HALT, all others go to EXEC.
  - FETCH2: read {0,PC+1}. On ready, latch w2. Ops 3/4 go to MEM, 7 goes to EXEC.
  - MEM: issue the load, store or wr access. On ready, latch load data into mdr and go to EXEC.
  - EXEC: register writeback (ALU result, mdr, sext imm, or PC+1 for jal) and PC update; then go to FETCH.
  - HALT: stays until reset. PC is not advanced.
- Each request holds `mem_addr`/`mem_we`/`mem_wdata` stable until the cycle in which `mem_ready`=1. Exactly one access completes per ready cycle.

## Timing
- Reset (async assert, sync-free deassert):
  - State is START. PC=`RESET_PC`. ir, w2, mdr and all R = 0.
  - Outputs are `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `halted`=0.
  - The first `mem_req` appears in the second cycle after deassertion.
- Outputs are combinational decodes of the registered state. `mem_req`=1 only in FETCH, FETCH2 and MEM.
- Zero-wait cycles per instruction: 2 for ALU ops, loadi, j, jal and halt (to HALT entry); 3 for beq and wr; 4 for load and store. Each wait cycle adds 1.
- A reset assertion mid-access drops `mem_req` immediately. The aborted write is the memory's concern.
- Register writes occur only at the EXEC edge, so read-after-write is satisfied across instructions.
- `mem_rdata` is ignored in any cycle without both `mem_req` and `mem_ready` high.

## Test plan
- Zero-wait memory with program `loadi r1,5; loadi r2,-3; add r3,r1,r2; halt`: r3 is 2; `halted` rises 7 cycles after the first fetch; `mem_req` stays 0 afterwards.
- Store then load through bank 2 at addr 0x0040, using R[4]=0xBEEF: write seen at {2,0x0040} with `mem_we`=1 for exactly one ready cycle; a later load puts 0xBEEF into R[5]; PC advances by 2 for each.
- Random 0–3 wait states on every access: addr/we/wdata stay stable while `mem_req`=1 ∧ `mem_ready`=0; final register contents match the zero-wait run.
- beq taken (R1==R2) to 0x0010 and not taken: the next fetch address is 0x0010 when taken and PC+2 when not; jal at PC 7 sets R15=8 and the next fetch is at the target.
- PC wrap with `PC_W`=4, `RESET_PC`=15: loadi at 15 is followed by a fetch at 0. With `DATA_W`=32, shl of 1 by 31 gives 0x80000000, and slt(−1,1) gives 1.
- Assert `rst_n` during a MEM wait on a store: `mem_req`/`mem_we` drop asynchronously; after release, fetch restarts at `RESET_PC` with registers cleared.
